// File: rtl/tile_renderer_if.sv
// Command and pixel-write bundle between the game FSM, tile_renderer and vga_adapter.
// master = the renderer (pixel-write initiator); slave = command source / pixel sink side.
interface tile_renderer_if;
    logic       req;
    logic       cmd_clear;
    logic [1:0] tile_col;
    logic [1:0] tile_row;
    logic [2:0] fill_color;
    logic       border_en;
    logic       stall;
    logic       busy;
    logic       done;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] color;
    logic       write;

    modport master (
        input  req, cmd_clear, tile_col, tile_row, fill_color, border_en, stall,
        output busy, done, x, y, color, write
    );

    modport slave (
        output req, cmd_clear, tile_col, tile_row, fill_color, border_en, stall,
        input  busy, done, x, y, color, write
    );
endinterface

// File: rtl/tile_renderer.sv
// Sweeps one draw command (tile fill or full-screen clear) out as one pixel write per
// cycle, row-major with x fastest; sink back-pressure via stall holds the sweep.
module tile_renderer #(
    parameter int unsigned TILE_W       = 160,
    parameter int unsigned TILE_H       = 120,
    parameter int unsigned SCR_W        = 640,
    parameter int unsigned SCR_H        = 480,
    parameter logic [2:0]  BORDER_COLOR = 3'b000
) (
    input logic             clock,
    input logic             reset,
    tile_renderer_if.master bus
);
    localparam logic [9:0] TW    = 10'(TILE_W);
    localparam logic [8:0] TH    = 9'(TILE_H);
    localparam logic [9:0] TW_M1 = 10'(TILE_W - 1);
    localparam logic [8:0] TH_M1 = 9'(TILE_H - 1);
    localparam logic [9:0] SW_M1 = 10'(SCR_W - 1);
    localparam logic [8:0] SH_M1 = 9'(SCR_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t     state_q, state_d;
    logic       cmd_clear_q, cmd_clear_d;
    logic [1:0] tile_col_q, tile_col_d;
    logic [1:0] tile_row_q, tile_row_d;
    logic [2:0] fill_color_q, fill_color_d;
    logic       border_en_q, border_en_d;
    logic [9:0] lx_q, lx_d;
    logic [8:0] ly_q, ly_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       write_q, write_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [2:0] color_q, color_d;

    logic       accept, emit;
    logic       e_clear, e_border, on_edge, is_last;
    logic [1:0] e_col, e_row;
    logic [2:0] e_fill, pix_color;
    logic [9:0] e_lx, w_m1, pix_x;
    logic [8:0] e_ly, h_m1, pix_y;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_clear_q  <= 1'b0;
            tile_col_q   <= '0;
            tile_row_q   <= '0;
            fill_color_q <= '0;
            border_en_q  <= 1'b0;
            lx_q         <= '0;
            ly_q         <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            write_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
        end else begin
            state_q      <= state_d;
            cmd_clear_q  <= cmd_clear_d;
            tile_col_q   <= tile_col_d;
            tile_row_q   <= tile_row_d;
            fill_color_q <= fill_color_d;
            border_en_q  <= border_en_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            write_q      <= write_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req) state_d = DRAW;
            DRAW:    if (last_q) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pixel (0,0) is emitted on the accept edge straight from the inputs so the first
    // write lands one cycle after acceptance; afterwards the latched command is used.
    assign accept = (state_q == IDLE) && bus.req;
    assign emit   = accept || ((state_q == DRAW) && !last_q && !bus.stall);

    always_comb begin
        e_clear  = accept ? bus.cmd_clear  : cmd_clear_q;
        e_col    = accept ? bus.tile_col   : tile_col_q;
        e_row    = accept ? bus.tile_row   : tile_row_q;
        e_fill   = accept ? bus.fill_color : fill_color_q;
        e_border = accept ? bus.border_en  : border_en_q;
        e_lx     = accept ? '0 : lx_q;
        e_ly     = accept ? '0 : ly_q;
        w_m1     = e_clear ? SW_M1 : TW_M1;
        h_m1     = e_clear ? SH_M1 : TH_M1;
        on_edge  = (e_lx == '0) || (e_lx == TW_M1) || (e_ly == '0) || (e_ly == TH_M1);
        pix_x    = e_clear ? e_lx : 10'(e_col) * TW + e_lx;
        pix_y    = e_clear ? e_ly : 9'(e_row) * TH + e_ly;
        pix_color = (!e_clear && e_border && on_edge) ? BORDER_COLOR : e_fill;
        is_last  = (e_lx == w_m1) && (e_ly == h_m1);
    end

    always_comb begin
        cmd_clear_d  = cmd_clear_q;
        tile_col_d   = tile_col_q;
        tile_row_d   = tile_row_q;
        fill_color_d = fill_color_q;
        border_en_d  = border_en_q;
        lx_d         = lx_q;
        ly_d         = ly_q;
        last_d       = (state_q == DRAW) ? last_q : 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        write_d      = 1'b0;
        busy_d       = (state_d == DRAW);
        done_d       = (state_d == FIN);
        if (accept) begin
            cmd_clear_d  = bus.cmd_clear;
            tile_col_d   = bus.tile_col;
            tile_row_d   = bus.tile_row;
            fill_color_d = bus.fill_color;
            border_en_d  = bus.border_en;
        end
        if (emit) begin
            write_d = 1'b1;
            x_d     = pix_x;
            y_d     = pix_y;
            color_d = pix_color;
            last_d  = is_last;
            lx_d    = (e_lx == w_m1) ? '0 : e_lx + 10'd1;
            ly_d    = (e_lx == w_m1) ? e_ly + 9'd1 : e_ly;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.write = write_q;
    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.color = color_q;
endmodule
